// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (watchdog enabled by PS2_TX_TIMEOUT_EN)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [3:0]       idx_q, idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic             dat_oe_q, dat_oe_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fe;
    logic frame_bit;
    logic wd_expire;

    // Two-stage synchronizers plus the edge register; lines idle high
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fe = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_active;

    assign wd_active = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_expire = wd_active && (wd_q >= WD_LAST);

    // Watchdog: REQ is cycle 0, counting continues until the frame leaves WAIT_IDLE
    always_comb begin
        wd_d = '0;
        if (state_q == S_REQ) begin
            wd_d = WD_W'(1);
        end else if (wd_active) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 32'd0);
`endif

    // Frame bit selected by the bit index: data LSB first, parity, stop
    always_comb begin
        frame_bit = 1'b1;
        if (idx_q < 4'd8) begin
            frame_bit = data_q[idx_q[2:0]];
        end else if (idx_q == 4'd8) begin
            frame_bit = parity_q;
        end
    end

    // State, frame and counter registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            inh_q    <= '0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            inh_q    <= inh_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    // Next-state logic; a watchdog expiry takes priority over any edge in the same cycle
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        inh_d    = inh_q;
        dat_oe_d = dat_oe_q;

        case (state_q)
            S_IDLE: begin
                inh_d    = '0;
                idx_d    = '0;
                dat_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    inh_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (wd_expire) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ERROR;
                end else if (fe) begin
                    dat_oe_d = ~frame_bit;
                    if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (wd_expire) begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ERROR;
                end else if (fe) begin
                    state_d = dat_sync_q ? S_ERROR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (wd_expire) begin
                    state_d = S_ERROR;
                end else if (clk_sync_q && dat_sync_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign tx_ready   = (state_q == S_IDLE);
    assign tx_done    = (state_q == S_DONE);
    assign tx_error   = (state_q == S_ERROR);
    assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int TMO = 200;
    localparam int H   = 6;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;

    logic dev_clk_rel = 1'b1;
    logic dev_dat_low = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk_rel;
    assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         par;
        int         dd;
        int         de;
    } vec_t;

    vec_t        vecs [4];
    logic [9:0]  exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0;
    int oe_run = 0, oe_last = 0, req_cyc = 0, err_cyc = 0;
    bit both_pulse = 1'b0;

    always @(negedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_pulse <= 1'b1;
        if (ps2_clk_oe) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            oe_last <= oe_run;
            oe_run  <= 0;
        end
        if (ps2_clk_oe && ps2_dat_oe) req_cyc <= cyc;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic present(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        check("accept_to_clk_oe", 32'(ps2_clk_oe), 32'd1);
    endtask

    // Device: waits for the request, clocks stop_after pulses (11 = full frame), acks if asked
    task automatic device(input bit ack, input int stop_after);
        logic [9:0] bits;
        int guard;
        bits  = '0;
        guard = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && guard < INH + 100) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (guard >= INH + 100) begin
            check("request_seen", 32'd0, 32'd1);
            return;
        end
        repeat (4) @(negedge CLOCK_50);
        for (int i = 0; i < 11; i++) begin
            if (i == stop_after) return;
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                @(negedge CLOCK_50);
            end
            dev_clk_rel = 1'b0;
            repeat (H) @(negedge CLOCK_50);
            if (i < 10) bits[i] = ps2_dat_in;
            dev_clk_rel = 1'b1;
            repeat (H) @(negedge CLOCK_50);
        end
        dev_dat_low = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(bits), 32'h3ff);
        end else begin
            check("frame_bits", 32'(bits), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!tx_ready && guard < 20000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (!tx_ready) check("ready_wait", 32'(tx_ready), 32'd1);
    endtask

    int dc0, ec0;

    initial begin
        vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, dd: 1, de: 0};
        vecs[1] = '{data: 8'h01, ack: 1'b1, par: 1'b0, dd: 1, de: 0};
        vecs[2] = '{data: 8'hFF, ack: 1'b0, par: 1'b1, dd: 0, de: 1};
        vecs[3] = '{data: 8'hA5, ack: 1'b1, par: 1'b1, dd: 1, de: 0};

        #25;
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        for (int v = 0; v < 4; v++) begin
            dc0 = done_cnt;
            ec0 = err_cnt;
            exp_q.push_back({1'b1, vecs[v].par, vecs[v].data});
            check("ready_before", 32'(tx_ready), 32'd1);
            fork
                present(vecs[v].data);
                device(vecs[v].ack, 11);
            join
            wait_ready();
            repeat (3) @(negedge CLOCK_50);
            check("clk_oe_len", 32'(oe_last), 32'(INH + 1));
            check("done_count", 32'(done_cnt - dc0), 32'(vecs[v].dd));
            check("error_count", 32'(err_cnt - ec0), 32'(vecs[v].de));
            check("clk_oe_after", 32'(ps2_clk_oe), 32'd0);
            check("dat_oe_after", 32'(ps2_dat_oe), 32'd0);
            check("ready_after", 32'(tx_ready), 32'd1);
        end

        // Busy: 0x55 held on tx_valid through a 0xED frame is only taken once idle
        dc0 = done_cnt;
        ec0 = err_cnt;
        exp_q.push_back({1'b1, 1'b1, 8'hED});
        exp_q.push_back({1'b1, 1'b1, 8'h55});
        fork
            begin
                tx_data  = 8'hED;
                tx_valid = 1'b1;
                @(negedge CLOCK_50);
                tx_data = 8'h55;
                check("busy_ready", 32'(tx_ready), 32'd0);
                wait_ready();
                @(negedge CLOCK_50);
                tx_valid = 1'b0;
                check("second_accept", 32'(ps2_clk_oe), 32'd1);
            end
            begin
                device(1'b1, 11);
                device(1'b1, 11);
            end
        join
        wait_ready();
        repeat (3) @(negedge CLOCK_50);
        check("busy_done_count", 32'(done_cnt - dc0), 32'd2);
        check("busy_error_count", 32'(err_cnt - ec0), 32'd0);
        check("busy_queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset after the 4th falling edge of a 0x00 frame
        fork
            present(8'h00);
            device(1'b1, 4);
        join
        check("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
        dc0 = done_cnt;
        ec0 = err_cnt;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_dat_oe", 32'(ps2_dat_oe), 32'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check("post_reset_ready", 32'(tx_ready), 32'd1);
        check("post_reset_pulses", 32'((done_cnt - dc0) + (err_cnt - ec0)), 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
        // Silent device: the watchdog fires TMO cycles after REQ
        dc0 = done_cnt;
        ec0 = err_cnt;
        fork
            present(8'h3C);
            device(1'b1, 0);
        join
        for (int g = 0; g < 2 * TMO && err_cnt == ec0; g++) @(negedge CLOCK_50);
        repeat (2) @(negedge CLOCK_50);
        check("timeout_error", 32'(err_cnt - ec0), 32'd1);
        check("timeout_delay", 32'(err_cyc - req_cyc), 32'(TMO));
        check("timeout_done", 32'(done_cnt - dc0), 32'd0);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
`endif

        check("pulse_exclusive", 32'(both_pulse), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
